fta_resp_dispatch: RTL and testbench

Downstream companion to the channel response merger. Takes the single merged `fta_cmd_response128_t` stream, one response per cycle at most and with no backpressure, and routes each response by its `cid` to one of `PORTS` destination ports. Each port has a `DEPTH`-entry FIFO and a ready handshake. Sits between the response merger and the bus masters (cores, DMA) so that a slow master cannot stall delivery to the others.

---
 rtl/fta_resp_dispatch_if.sv | 35 +++
 rtl/fta_resp_dispatch.sv | 87 ++++++++
 tb/tb_fta_resp_dispatch.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fta_resp_dispatch_if.sv
// Response format shared by the merger and the dispatcher, and the dispatcher's port bundle.
package fta_pkg;
  typedef enum logic [1:0] {OKAY = 2'd0, SLVERR = 2'd1, DECERR = 2'd2, RETRY = 2'd3} fta_err_t;

  typedef struct packed {
    logic         ack;
    logic         stall;
    logic         next;
    fta_err_t     err;
    logic [3:0]   pri;
    logic [7:0]   cid;
    logic [7:0]   tid;
    logic [31:0]  adr;
    logic [127:0] dat;
  } fta_cmd_response128_t;

  localparam fta_cmd_response128_t RESP_IDLE = '{ack: 1'b0, stall: 1'b0, next: 1'b0, err: OKAY,
                                                 pri: 4'hF, cid: 8'h00, tid: 8'h00,
                                                 adr: 32'h0, dat: 128'h0};
endpackage

interface fta_resp_dispatch_if
  import fta_pkg::*;
#(
  parameter int PORTS = 4
);
  fta_cmd_response128_t             resp;
  fta_cmd_response128_t [PORTS-1:0] resp_o;
  logic [PORTS-1:0]                 rdy;
  logic [PORTS-1:0]                 ovf;
  logic [7:0]                       drop_cnt;

  modport master (output resp, rdy, input resp_o, ovf, drop_cnt);
  modport slave  (input resp, rdy, output resp_o, ovf, drop_cnt);
endinterface

// File: rtl/fta_resp_dispatch.sv
// Routes the merged response stream by cid into per-port FIFOs so one slow master
// cannot hold up delivery to the others.
module fta_resp_dispatch
  import fta_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  fta_resp_dispatch_if.slave bus
);
  localparam int SW = $clog2(PORTS);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [SW-1:0]        sel;
  fta_cmd_response128_t wdata;
  fta_cmd_response128_t head [PORTS];
  logic [PORTS-1:0]     drop;
  logic [PORTS-1:0]     ovf_q;
  logic [7:0]           drop_q;

  assign sel = bus.resp.cid[SW-1:0];

  // Stored entries always present as a plain valid response to the master.
  always_comb begin
    wdata       = bus.resp;
    wdata.ack   = 1'b1;
    wdata.stall = 1'b0;
    wdata.next  = 1'b0;
  end

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    fta_cmd_response128_t mem [DEPTH];
    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        wr_ptr;
    logic [CW-1:0]        cnt;
    logic                 hit;
    logic                 pop;
    logic                 push;

    assign hit     = bus.resp.ack && (sel == SW'(p));
    assign pop     = (cnt != '0) && bus.rdy[p];
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push    = hit && ((cnt != FULL_CNT) || pop);
    assign drop[p] = hit && !push;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (push && !pop)      cnt <= cnt + 1'b1;
        else if (pop && !push) cnt <= cnt - 1'b1;
      end
    end

    // Storage needs no reset: the head is masked by cnt until written.
    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
    end

    assign head[p] = (cnt != '0) ? mem[rd_ptr] : RESP_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q  <= '0;
      drop_q <= '0;
    end else begin
      ovf_q <= ovf_q | drop;
      if ((|drop) && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
    end
  end

  always_comb begin
    for (int p = 0; p < PORTS; p++) bus.resp_o[p] = head[p];
  end

  assign bus.ovf      = ovf_q;
  assign bus.drop_cnt = drop_q;
endmodule

// File: tb/tb_fta_resp_dispatch.sv
// Bench for fta_resp_dispatch: table vectors, directed corner sequences and a
// random phase, all checked against a queue-based reference model.
module tb_fta_resp_dispatch;
  import fta_pkg::*;

  localparam int PORTS = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fta_resp_dispatch_if #(.PORTS(PORTS)) bus ();
  fta_resp_dispatch #(.PORTS(PORTS), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  fta_cmd_response128_t mq [PORTS][$];
  logic [PORTS-1:0]     m_ovf;
  int                   m_drop;
  logic [7:0]           dq [PORTS][$];

  typedef struct {
    logic            ack;
    logic [7:0]      cid;
    logic [7:0]      tid;
    logic [3:0]      rdy;
    logic [3:0]      e_ack;
    logic [3:0][7:0] e_tid;
    logic [3:0]      e_ovf;
    int              e_drop;
  } vec_t;
  vec_t tbl [$];

  function automatic fta_cmd_response128_t idle_resp();
    fta_cmd_response128_t r;
    r     = '0;
    r.err = OKAY;
    r.pri = 4'hF;
    return r;
  endfunction

  function automatic fta_cmd_response128_t mk(logic a, logic [7:0] cid, logic [7:0] tid);
    fta_cmd_response128_t r;
    r.ack   = a;
    r.stall = 1'($urandom);
    r.next  = 1'($urandom);
    r.err   = fta_err_t'($urandom_range(0, 3));
    r.pri   = 4'($urandom);
    r.cid   = cid;
    r.tid   = tid;
    r.adr   = $urandom;
    r.dat   = {$urandom, $urandom, $urandom, $urandom};
    return r;
  endfunction

  task automatic chk_val(string nm, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_resp(string nm, int p, fta_cmd_response128_t act, fta_cmd_response128_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s port%0d: got %h, expected %h", nm, p, act, exp);
    end
  endtask

  task automatic check_model(string nm);
    for (int p = 0; p < PORTS; p++)
      chk_resp(nm, p, bus.resp_o[p], (mq[p].size() != 0) ? mq[p][0] : idle_resp());
    chk_val({nm, "_ovf"}, 128'(bus.ovf), 128'(m_ovf));
    chk_val({nm, "_drop"}, 128'(bus.drop_cnt), 128'(m_drop));
  endtask

  task automatic model_clear();
    for (int p = 0; p < PORTS; p++) begin
      mq[p].delete();
      dq[p].delete();
    end
    m_ovf  = '0;
    m_drop = 0;
  endtask

  // One clock: drive inputs, update the model at the edge, compare 1 time unit later.
  task automatic step(fta_cmd_response128_t r, logic [PORTS-1:0] rd, string nm);
    logic [PORTS-1:0]     pop;
    fta_cmd_response128_t w;
    int                   s;
    for (int p = 0; p < PORTS; p++)
      if (bus.resp_o[p].ack && rd[p]) dq[p].push_back(bus.resp_o[p].tid);
    bus.resp = r;
    bus.rdy  = rd;
    @(posedge clk);
    for (int p = 0; p < PORTS; p++) pop[p] = (mq[p].size() != 0) && rd[p];
    for (int p = 0; p < PORTS; p++) if (pop[p]) void'(mq[p].pop_front());
    if (r.ack) begin
      s = int'(r.cid) % PORTS;
      if (mq[s].size() < DEPTH) begin
        w       = r;
        w.ack   = 1'b1;
        w.stall = 1'b0;
        w.next  = 1'b0;
        mq[s].push_back(w);
      end else begin
        m_ovf[s] = 1'b1;
        if (m_drop < 255) m_drop++;
      end
    end
    #1;
    check_model(nm);
  endtask

  task automatic add(logic a, logic [7:0] cid, logic [7:0] tid, logic [3:0] rd, logic [3:0] ea,
                     logic [3:0][7:0] et, logic [3:0] eo, int ed);
    vec_t v;
    v.ack = a; v.cid = cid; v.tid = tid; v.rdy = rd;
    v.e_ack = ea; v.e_tid = et; v.e_ovf = eo; v.e_drop = ed;
    tbl.push_back(v);
  endtask

  initial begin
    fta_cmd_response128_t r;
    bus.resp = '0;
    bus.rdy  = '0;
    model_clear();

    // Routing: cid 0..7 fill two entries per port, then drain.
    add(1, 8'd0, 8'h10, 4'h0, 4'b0001, {8'h00, 8'h00, 8'h00, 8'h10}, 4'h0, 0);
    add(1, 8'd1, 8'h11, 4'h0, 4'b0011, {8'h00, 8'h00, 8'h11, 8'h10}, 4'h0, 0);
    add(1, 8'd2, 8'h12, 4'h0, 4'b0111, {8'h00, 8'h12, 8'h11, 8'h10}, 4'h0, 0);
    add(1, 8'd3, 8'h13, 4'h0, 4'b1111, {8'h13, 8'h12, 8'h11, 8'h10}, 4'h0, 0);
    for (int i = 4; i < 8; i++)
      add(1, 8'(i), 8'(8'h10 + i), 4'h0, 4'b1111, {8'h13, 8'h12, 8'h11, 8'h10}, 4'h0, 0);
    add(0, 8'd0, 8'h00, 4'hF, 4'b1111, {8'h17, 8'h16, 8'h15, 8'h14}, 4'h0, 0);
    add(0, 8'd0, 8'h00, 4'hF, 4'b0000, {8'h00, 8'h00, 8'h00, 8'h00}, 4'h0, 0);
    // Overflow: six pushes to port 1, last two dropped, then pop 1..4.
    for (int i = 1; i <= 4; i++)
      add(1, 8'd1, 8'(i), 4'h0, 4'b0010, {8'h00, 8'h00, 8'h01, 8'h00}, 4'h0, 0);
    add(1, 8'd1, 8'd5, 4'h0, 4'b0010, {8'h00, 8'h00, 8'h01, 8'h00}, 4'b0010, 1);
    add(1, 8'd1, 8'd6, 4'h0, 4'b0010, {8'h00, 8'h00, 8'h01, 8'h00}, 4'b0010, 2);
    add(0, 8'd0, 8'd0, 4'b0010, 4'b0010, {8'h00, 8'h00, 8'h02, 8'h00}, 4'b0010, 2);
    add(0, 8'd0, 8'd0, 4'b0010, 4'b0010, {8'h00, 8'h00, 8'h03, 8'h00}, 4'b0010, 2);
    add(0, 8'd0, 8'd0, 4'b0010, 4'b0010, {8'h00, 8'h00, 8'h04, 8'h00}, 4'b0010, 2);
    add(0, 8'd0, 8'd0, 4'b0010, 4'b0000, {8'h00, 8'h00, 8'h00, 8'h00}, 4'b0010, 2);

    // Reset held with random inputs.
    for (int c = 0; c < 3; c++) begin
      bus.resp = mk(1'($urandom), 8'($urandom), 8'($urandom));
      bus.rdy  = 4'($urandom);
      @(posedge clk);
      #1;
      for (int p = 0; p < PORTS; p++) begin
        chk_val("rst_ack", 128'(bus.resp_o[p].ack), 128'(0));
        chk_val("rst_pri", 128'(bus.resp_o[p].pri), 128'(4'hF));
      end
      chk_val("rst_ovf", 128'(bus.ovf), 128'(0));
      chk_val("rst_drop", 128'(bus.drop_cnt), 128'(0));
    end
    bus.resp = '0;
    bus.rdy  = '0;
    rst      = 1'b1;

    // First push after reset.
    r     = mk(1'b1, 8'd2, 8'h5A);
    r.adr = 32'h1234_5678;
    r.dat = {4{32'hA5A5_A5A5}};
    step(r, 4'h0, "first");
    chk_val("first_ack", 128'(bus.resp_o[2].ack), 128'(1));
    chk_val("first_dat", bus.resp_o[2].dat, {4{32'hA5A5_A5A5}});
    chk_val("first_tid", 128'(bus.resp_o[2].tid), 128'(8'h5A));
    chk_val("first_adr", 128'(bus.resp_o[2].adr), 128'(32'h1234_5678));
    chk_val("first_others", 128'({bus.resp_o[3].ack, bus.resp_o[1].ack, bus.resp_o[0].ack}), 128'(0));
    step(mk(1'b0, 8'd0, 8'd0), 4'b0100, "first_drain");

    foreach (tbl[i]) begin
      step(mk(tbl[i].ack, tbl[i].cid, tbl[i].tid), tbl[i].rdy, "tbl_model");
      for (int p = 0; p < PORTS; p++) begin
        chk_val("tbl_ack", 128'(bus.resp_o[p].ack), 128'(tbl[i].e_ack[p]));
        chk_val("tbl_tid", 128'(bus.resp_o[p].tid), 128'(tbl[i].e_tid[p]));
      end
      chk_val("tbl_ovf", 128'(bus.ovf), 128'(tbl[i].e_ovf));
      chk_val("tbl_drop", 128'(bus.drop_cnt), 128'(tbl[i].e_drop));
    end

    // Full port 3 accepts a push when it pops in the same cycle.
    dq[3].delete();
    for (int i = 0; i < 4; i++) step(mk(1'b1, 8'd3, 8'(8'h31 + i)), 4'h0, "full_fill");
    step(mk(1'b1, 8'd7, 8'h35), 4'b1000, "full_pp");
    chk_val("full_pp_head", 128'(bus.resp_o[3].tid), 128'(8'h32));
    chk_val("full_pp_ovf3", 128'(bus.ovf[3]), 128'(0));
    chk_val("full_pp_drop", 128'(bus.drop_cnt), 128'(2));
    for (int i = 0; i < 5; i++) step(mk(1'b0, 8'd0, 8'd0), 4'b1000, "full_drain");
    chk_val("full_cnt", 128'(dq[3].size()), 128'(5));
    for (int i = 0; i < 5 && i < dq[3].size(); i++)
      chk_val("full_order", 128'(dq[3][i]), 128'(8'h31 + i));

    // Wrap-around: 20 responses through port 0 with rdy toggling.
    dq[0].delete();
    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0) step(mk(1'b1, 8'((k / 2) * 4), 8'(k / 2)), 4'h0, "wrap");
      else            step(mk(1'b0, 8'd0, 8'd0), 4'b0001, "wrap");
    end
    step(mk(1'b0, 8'd0, 8'd0), 4'b0001, "wrap");
    chk_val("wrap_cnt", 128'(dq[0].size()), 128'(20));
    for (int i = 0; i < 20 && i < dq[0].size(); i++)
      chk_val("wrap_order", 128'(dq[0][i]), 128'(i));
    chk_val("wrap_drop", 128'(bus.drop_cnt), 128'(2));

    // Drop counter saturation.
    for (int i = 0; i < 260; i++) step(mk(1'b1, 8'd3, 8'(i)), 4'h0, "sat");
    chk_val("sat_drop", 128'(bus.drop_cnt), 128'(255));

    // Mid-stream reset with buffered entries and ovf set.
    for (int i = 0; i < 3; i++) step(mk(1'b1, 8'd0, 8'(8'h40 + i)), 4'h0, "mid_fill");
    for (int i = 0; i < 5; i++) step(mk(1'b1, 8'd2, 8'(8'h50 + i)), 4'h0, "mid_fill");
    rst = 1'b0;
    #2;
    model_clear();
    check_model("mid_rst");
    for (int p = 0; p < PORTS; p++) chk_val("mid_rst_ack", 128'(bus.resp_o[p].ack), 128'(0));
    chk_val("mid_rst_ovf", 128'(bus.ovf), 128'(0));
    @(posedge clk);
    #1;
    bus.resp = '0;
    bus.rdy  = '0;
    rst      = 1'b1;
    step(mk(1'b1, 8'd2, 8'h77), 4'h0, "mid_after");
    chk_val("mid_after_tid", 128'(bus.resp_o[2].tid), 128'(8'h77));
    step(mk(1'b0, 8'd0, 8'd0), 4'hF, "mid_after");

    // Random traffic: slow consumers first, then faster ones.
    for (int c = 0; c < 600; c++) begin
      logic [3:0] rd;
      rd = (c < 300) ? 4'($urandom & $urandom & $urandom) : 4'($urandom | $urandom);
      step(mk(1'(($urandom % 4) != 0), 8'($urandom), 8'($urandom)), rd, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
